// File: rtl/dbnc_pkg.sv
// Shared definitions for the debounce/edge conditioning stage.
// Holds the FSM state encoding and the default configuration constants
// used by debounce_edge and sync_chain.
package dbnc_pkg;

  // IDLE_* states hold a settled level and WAIT_* states qualify a
  // candidate new level. Bit 1 of the encoding follows the settled level.
  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    WAIT_HI = 2'd1,
    IDLE_HI = 2'd2,
    WAIT_LO = 2'd3
  } dbnc_state_e;

  // Default number of synchronizer flops (minimum 2).
  localparam int DBNC_SYNC_STAGES = 2;
  // Default number of extra consecutive samples needed to accept a level.
  localparam int DBNC_STABLE_CNT  = 4;
  // Default counter width; 2**DBNC_CNT_W must exceed DBNC_STABLE_CNT-1.
  localparam int DBNC_CNT_W       = 4;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for a single asynchronous bit.
// Also used by other clock-crossing inputs, so it is kept generic.
//
// Parameters:
//   SYNC_STAGES - number of flops in the chain (minimum 2)
// Ports:
//   i_clk - clock, all flops update on the rising edge
//   i_rst - synchronous active-high reset, clears every flop
//   i_D   - raw asynchronous input
//   o_Q   - synchronized output (last flop of the chain)
module sync_chain
  import dbnc_pkg::*;
#(
  parameter int SYNC_STAGES = DBNC_SYNC_STAGES
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_D,
  output logic o_Q
);

  logic [SYNC_STAGES-1:0] chain_q;

  // Shift the raw input through the chain. The first flop may go
  // metastable; the remaining flops give it time to resolve before the
  // value is used by synchronous logic.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], i_D};
    end
  end

  assign o_Q = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_edge.sv
// Debounce and edge-detect conditioning stage for a raw, bouncy 1-bit input.
// The input is synchronized, then a new level is accepted only after it has
// been seen on STABLE_CNT+1 consecutive clock edges. The accepted level is
// presented as a registered output, plus one-cycle rise/fall pulses.
//
// Optional feature macro: DEBOUNCE_EDGE_PULSE_EN
//   defined   - o_rise/o_fall are registered one-cycle pulses
//   undefined - no edge registers; o_rise/o_fall are tied to 0
//
// Parameters:
//   SYNC_STAGES - synchronizer depth (minimum 2)
//   STABLE_CNT  - extra consecutive samples to accept a level (minimum 1)
//   CNT_W       - counter width, 2**CNT_W > STABLE_CNT-1
// Ports:
//   i_clk  - clock, all state updates on the rising edge
//   i_rst  - synchronous active-high reset
//   i_D    - raw asynchronous input
//   o_Q    - debounced registered level
//   o_rise - one-cycle pulse when o_Q goes 0->1
//   o_fall - one-cycle pulse when o_Q goes 1->0
module debounce_edge
  import dbnc_pkg::*;
#(
  parameter int SYNC_STAGES = DBNC_SYNC_STAGES,
  parameter int STABLE_CNT  = DBNC_STABLE_CNT,
  parameter int CNT_W       = DBNC_CNT_W
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_D,
  output logic o_Q,
  output logic o_rise,
  output logic o_fall
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(STABLE_CNT - 1);

  dbnc_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             sync_s;

  sync_chain #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_D  (i_D),
    .o_Q  (sync_s)
  );

  // State, qualification counter and accepted level. Reset returns the
  // stage to a settled low level regardless of any qualification in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE_LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  // Next-state logic. An IDLE state leaves for WAIT on the first sample that
  // differs from the settled level. In WAIT, any sample matching the old
  // level is treated as bounce and drops straight back to IDLE, so the next
  // differing sample starts qualification from zero again. The counter is
  // cleared on every IDLE<->WAIT move and saturates at CntMax by
  // construction, because reaching CntMax with a still-differing sample
  // always leaves WAIT.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    case (state_q)
      IDLE_LO: begin
        if (sync_s) begin
          state_d = WAIT_HI;
          cnt_d   = '0;
        end
      end
      WAIT_HI: begin
        if (!sync_s) begin
          state_d = IDLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          state_d = IDLE_HI;
          cnt_d   = '0;
          level_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      IDLE_HI: begin
        if (!sync_s) begin
          state_d = WAIT_LO;
          cnt_d   = '0;
        end
      end
      WAIT_LO: begin
        if (sync_s) begin
          state_d = IDLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          state_d = IDLE_LO;
          cnt_d   = '0;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  assign o_Q = level_q;

`ifdef DEBOUNCE_EDGE_PULSE_EN
  logic rise_q, fall_q;
  logic rise_d, fall_d;

  // A pulse is due exactly when the accepted level is about to change, so
  // it is registered alongside level_q and appears in the same cycle as
  // the new o_Q value. Only one direction can change at a time.
  assign rise_d = level_d & ~level_q;
  assign fall_d = ~level_d & level_q;

  // Edge pulse registers, cleared by reset so no pulse survives it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign o_rise = rise_q;
  assign o_fall = fall_q;
`else
  assign o_rise = 1'b0;
  assign o_fall = 1'b0;
`endif

endmodule
